// File: rtl/write_master_arbiter.sv
// write_master_arbiter: two-master AXI write-channel arbiter and transaction sequencer.
//
// Grants M0 or M1 for a whole write transaction and holds that grant through the
// address, data and response phases. It also counts W beats against the captured
// AWLEN and pulses lenError on a burst-length mismatch.
//
// Configuration macro: WRITE_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin; on a tie, the master that is not lastGrant wins.
//   undefined -> fixed priority; on a tie, M0 wins.
//
// Ports:
//   clock, reset                      clock; synchronous active-high reset
//   AWVALID_Mx, AWADDR_Mx, AWLEN_Mx   per-master write-address requests
//   AWREADY                           address ready from the decoder side
//   WVALID, WREADY, WLAST             muxed W handshake of the granted master
//   BVALID, BREADY                    muxed B handshake
//   AWVALID, AWADDR, MasterID         forwarded address phase and ID of the granted master
//   Write{Address,Data,Response}Sel   bridge selects: 00 none, 01 M0, 10 M1
//   finish                            one-cycle pulse on the B handshake
//   lenError                          one-cycle pulse on a burst-length mismatch
module write_master_arbiter #(
    parameter logic [3:0] M0_ID = 4'd1,
    parameter logic [3:0] M1_ID = 4'd2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        AWVALID_M0,
    input  logic        AWVALID_M1,
    input  logic [31:0] AWADDR_M0,
    input  logic [31:0] AWADDR_M1,
    input  logic [3:0]  AWLEN_M0,
    input  logic [3:0]  AWLEN_M1,
    input  logic        AWREADY,
    input  logic        WVALID,
    input  logic        WREADY,
    input  logic        WLAST,
    input  logic        BVALID,
    input  logic        BREADY,
    output logic        AWVALID,
    output logic [31:0] AWADDR,
    output logic [3:0]  MasterID,
    output logic [1:0]  WriteAddressSel,
    output logic [1:0]  WriteDataSel,
    output logic [1:0]  WriteResponseSel,
    output logic        finish,
    output logic        lenError
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;            // 0 = M0, 1 = M1
    logic        last_grant_q, last_grant_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic [3:0]  len_q, len_d;

    logic        arb_winner;
    logic [1:0]  grant_sel;
    logic [3:0]  grant_id;
    logic        mux_awvalid;
    logic [31:0] mux_awaddr;
    logic [3:0]  mux_awlen;

    // Tie-break between simultaneous requests; a lone requester always wins.
`ifdef WRITE_ARB_ROUND_ROBIN_EN
    always_comb begin
        if (AWVALID_M0 && AWVALID_M1) arb_winner = ~last_grant_q;
        else                          arb_winner = AWVALID_M1;
    end
`else
    // Fixed priority still tracks lastGrant but never consults it.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
    always_comb begin
        if (AWVALID_M0 && AWVALID_M1) arb_winner = 1'b0;
        else                          arb_winner = AWVALID_M1;
    end
`endif

    assign grant_sel   = grant_q ? 2'b10 : 2'b01;
    assign grant_id    = grant_q ? M1_ID : M0_ID;
    assign mux_awvalid = grant_q ? AWVALID_M1 : AWVALID_M0;
    assign mux_awaddr  = grant_q ? AWADDR_M1 : AWADDR_M0;
    assign mux_awlen   = grant_q ? AWLEN_M1 : AWLEN_M0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= 4'd0;
            len_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_grant_d     = last_grant_q;
        beat_cnt_d       = beat_cnt_q;
        len_d            = len_q;
        AWVALID          = 1'b0;
        AWADDR           = 32'd0;
        MasterID         = 4'd0;
        WriteAddressSel  = 2'b00;
        WriteDataSel     = 2'b00;
        WriteResponseSel = 2'b00;
        finish           = 1'b0;
        lenError         = 1'b0;

        case (state_q)
            StIdle: begin
                if (AWVALID_M0 || AWVALID_M1) begin
                    grant_d = arb_winner;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                WriteAddressSel = grant_sel;
                AWVALID         = mux_awvalid;
                AWADDR          = mux_awaddr;
                MasterID        = grant_id;
                if (mux_awvalid && AWREADY) begin
                    len_d      = mux_awlen;
                    beat_cnt_d = 4'd0;
                    state_d    = StData;
                end
            end
            StData: begin
                WriteDataSel = grant_sel;
                MasterID     = grant_id;
                if (WVALID && WREADY) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    if (WLAST) begin
                        // beat_cnt_q is the zero-based index of this beat
                        lenError = (beat_cnt_q != len_q);
                        state_d  = StResp;
                    end else begin
                        lenError = (beat_cnt_q == len_q);
                    end
                end
            end
            StResp: begin
                WriteResponseSel = grant_sel;
                MasterID         = grant_id;
                if (BVALID && BREADY) begin
                    finish       = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_write_master_arbiter.sv
// Self-checking bench for write_master_arbiter: directed scenarios followed by
// randomized transactions, checked against a transaction-level reference model.
module tb_write_master_arbiter;

    localparam logic [3:0] ID0 = 4'd1;
    localparam logic [3:0] ID1 = 4'd2;
`ifdef WRITE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        AWVALID_M0, AWVALID_M1;
    logic [31:0] AWADDR_M0, AWADDR_M1;
    logic [3:0]  AWLEN_M0, AWLEN_M1;
    logic        AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic        AWVALID;
    logic [31:0] AWADDR;
    logic [3:0]  MasterID;
    logic [1:0]  WriteAddressSel, WriteDataSel, WriteResponseSel;
    logic        finish, lenError;

    int checks   = 0;
    int failures = 0;
    bit last_grant;   // model: 0 = M0, 1 = M1

    write_master_arbiter #(.M0_ID(ID0), .M1_ID(ID1)) dut (
        .clock(clock), .reset(reset),
        .AWVALID_M0(AWVALID_M0), .AWVALID_M1(AWVALID_M1),
        .AWADDR_M0(AWADDR_M0), .AWADDR_M1(AWADDR_M1),
        .AWLEN_M0(AWLEN_M0), .AWLEN_M1(AWLEN_M1),
        .AWREADY(AWREADY), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY),
        .AWVALID(AWVALID), .AWADDR(AWADDR), .MasterID(MasterID),
        .WriteAddressSel(WriteAddressSel), .WriteDataSel(WriteDataSel),
        .WriteResponseSel(WriteResponseSel), .finish(finish), .lenError(lenError)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_as"}, WriteAddressSel, 2'b00);
        chk({tag, "_ds"}, WriteDataSel, 2'b00);
        chk({tag, "_rs"}, WriteResponseSel, 2'b00);
        chk({tag, "_awv"}, AWVALID, 1'b0);
        chk({tag, "_awaddr"}, AWADDR, 32'd0);
        chk({tag, "_id"}, MasterID, 4'd0);
        chk({tag, "_fin"}, finish, 1'b0);
        chk({tag, "_err"}, lenError, 1'b0);
    endtask

    task automatic clear_inputs();
        AWVALID_M0 = 0; AWVALID_M1 = 0; AWADDR_M0 = 0; AWADDR_M1 = 0;
        AWLEN_M0 = 0; AWLEN_M1 = 0; AWREADY = 0;
        WVALID = 0; WREADY = 0; WLAST = 0; BVALID = 0; BREADY = 0;
    endtask

    // One full transaction starting in IDLE; returns in IDLE just after an edge.
    task automatic txn(input bit r0, input bit r1, input logic [3:0] l0, input logic [3:0] l1,
                       input int nbeats, input int aw_wait, input int b_wait, input bit gaps);
        logic [31:0] a0, a1, addr;
        logic [3:0]  len, id;
        logic [1:0]  sel;
        bit          w, last, exp_err;
        a0 = $urandom;
        a1 = $urandom;
        if (r0 && r1) w = RR ? !last_grant : 1'b0;
        else          w = r1;
        sel  = w ? 2'b10 : 2'b01;
        id   = w ? ID1 : ID0;
        len  = w ? l1 : l0;
        addr = w ? a1 : a0;

        AWVALID_M0 = r0; AWVALID_M1 = r1;
        AWADDR_M0 = a0; AWADDR_M1 = a1;
        AWLEN_M0 = l0; AWLEN_M1 = l1;
        #1;
        chk_idle("idle");
        tick();

        for (int i = 0; i <= aw_wait; i++) begin
            AWREADY = (i == aw_wait);
            #1;
            chk("addr_as", WriteAddressSel, sel);
            chk("addr_ds", WriteDataSel, 2'b00);
            chk("addr_awv", AWVALID, 1'b1);
            chk("addr_awaddr", AWADDR, addr);
            chk("addr_id", MasterID, id);
            tick();
        end
        AWVALID_M0 = 0; AWVALID_M1 = 0; AWREADY = 0;

        for (int b = 0; b < nbeats; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                WVALID = 1; WREADY = 0; WLAST = 0;
                #1;
                chk("gap_ds", WriteDataSel, sel);
                chk("gap_err", lenError, 1'b0);
                tick();
            end
            last    = (b == nbeats - 1);
            exp_err = last ? (4'(b) != len) : (4'(b) == len);
            WVALID = 1; WREADY = 1; WLAST = last;
            #1;
            chk("data_ds", WriteDataSel, sel);
            chk("data_as", WriteAddressSel, 2'b00);
            chk("data_awv", AWVALID, 1'b0);
            chk("data_id", MasterID, id);
            chk("data_err", lenError, exp_err);
            tick();
        end
        WVALID = 0; WREADY = 0; WLAST = 0;

        for (int i = 0; i <= b_wait; i++) begin
            BVALID = 1; BREADY = (i == b_wait);
            #1;
            chk("resp_rs", WriteResponseSel, sel);
            chk("resp_ds", WriteDataSel, 2'b00);
            chk("resp_fin", finish, i == b_wait);
            chk("resp_err", lenError, 1'b0);
            tick();
        end
        BVALID = 0; BREADY = 0;
        last_grant = w;
    endtask

    initial begin
        logic [3:0] l0, l1, len;
        bit r0, r1;
        int nb;

        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        last_grant = 1'b1;
        #1;
        chk_idle("reset");

        // Single M1 write, AWLEN 0, ready inputs high.
        txn(1'b0, 1'b1, 4'd0, 4'd0, 1, 0, 0, 1'b0);

        // Both masters request continuously, AWLEN 3.
        for (int k = 0; k < 3; k++) txn(1'b1, 1'b1, 4'd3, 4'd3, 4, 0, 0, 1'b0);

        // Short burst: AWLEN 3 with WLAST on beat 2.
        txn(1'b1, 1'b0, 4'd3, 4'd0, 2, 0, 0, 1'b0);

        // Long burst: AWLEN 1 with WLAST only on beat 4.
        txn(1'b1, 1'b0, 4'd1, 4'd0, 4, 0, 0, 1'b0);

        // AWREADY held low for 5 cycles.
        txn(1'b1, 1'b0, 4'd0, 4'd0, 1, 5, 0, 1'b0);

        // BVALID without BREADY for 3 cycles.
        txn(1'b0, 1'b1, 4'd2, 4'd2, 3, 0, 3, 1'b0);

        // Reset during DATA, then a new M1 request.
        AWVALID_M0 = 1; AWLEN_M0 = 4'd3; AWADDR_M0 = 32'h1234_5678;
        tick();
        AWREADY = 1;
        tick();
        AWVALID_M0 = 0; AWREADY = 0;
        WVALID = 1; WREADY = 1; WLAST = 0;
        #1;
        chk("prerst_ds", WriteDataSel, 2'b01);
        reset = 1;
        tick();
        reset = 0;
        WVALID = 0; WREADY = 0;
        last_grant = 1'b1;
        #1;
        chk("rst_as", WriteAddressSel, 2'b00);
        chk("rst_ds", WriteDataSel, 2'b00);
        chk("rst_rs", WriteResponseSel, 2'b00);
        txn(1'b0, 1'b1, 4'd0, 4'd0, 1, 0, 0, 1'b0);

        // Tie right after the reset above.
        txn(1'b1, 1'b1, 4'd0, 4'd0, 1, 0, 0, 1'b0);

        // Randomized transactions.
        for (int k = 0; k < 60; k++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            l0 = 4'($urandom_range(0, 7));
            l1 = 4'($urandom_range(0, 7));
            if (r0 && r1) len = (RR ? !last_grant : 1'b0) ? l1 : l0;
            else          len = r1 ? l1 : l0;
            if ($urandom_range(0, 1) == 0) nb = int'(len) + 1;
            else                           nb = $urandom_range(1, int'(len) + 3);
            txn(r0, r1, l0, l1, nb, $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/write_master_arbiter.md
# write_master_arbiter

Two-master write-channel arbiter and transaction sequencer for the AXI write path. It picks one of master M0 or M1 for a complete write transaction and holds that grant through the address, data and response phases. It drives the master-side bridge selects (`WriteAddressSel`, `WriteDataSel`, `WriteResponseSel`), the forwarded `AWVALID`/`AWADDR`/`MasterID`, and a one-cycle `finish` pulse to the write decoder. It also counts W beats against the captured `AWLEN` and flags burst-length violations.

## Interface
Parameters:
- `M0_ID`, default 4'd1: `MasterID` value driven while M0 is granted.
- `M1_ID`, default 4'd2: `MasterID` value driven while M1 is granted.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `AWVALID_M0` / `AWVALID_M1`  in  1  write-address request from each master.
- `AWADDR_M0` / `AWADDR_M1`  in  32  write address from each master.
- `AWLEN_M0` / `AWLEN_M1`  in  4  burst length minus 1, from each master.
- `AWREADY`  in  1  address-channel ready, returned from the decoder side.
- `WVALID`, `WREADY`, `WLAST`  in  1 each  muxed W-channel handshake of the granted master.
- `BVALID`, `BREADY`  in  1 each  muxed B-channel handshake.
- `AWVALID`  out  1  forwarded address valid.
- `AWADDR`  out  32  forwarded address.
- `MasterID`  out  4  ID of the granted master.
- `WriteAddressSel`, `WriteDataSel`, `WriteResponseSel`  out  2 each  selects; encoding 2'b00 = none, 2'b01 = M0, 2'b10 = M1.
- `finish`  out  1  one-cycle pulse on B handshake.
- `lenError`  out  1  one-cycle pulse on a burst-length mismatch.

## Operation
- FSM states and registers:
  - States: IDLE, ADDR, DATA, RESP.
  - `grant` register (M0/M1).
  - `lastGrant` register.
  - `beatCnt` (4 bits).
  - `lenReg` (4 bits).
- IDLE:
  - All selects are 2'b00; `AWVALID`, `AWADDR` and `MasterID` are 0.
  - If any `AWVALID_Mx` is high, arbitrate, load `grant`, and go to ADDR.
- ADDR:
  - `WriteAddressSel` = `grant`.
  - `AWVALID` and `AWADDR` are the granted master's inputs, passed through combinationally.
  - `MasterID` = `Mx_ID`.
  - On `AWVALID && AWREADY`: capture the granted `AWLEN` into `lenReg`, clear `beatCnt`, go to DATA.
- DATA:
  - `WriteDataSel` = `grant`; `MasterID` is held.
  - Each `WVALID && WREADY` beat increments `beatCnt`.
  - On a beat with `WLAST` = 1: go to RESP, and pulse `lenError` if `beatCnt` != `lenReg` at that beat.
  - A beat without `WLAST` when `beatCnt` == `lenReg` also pulses `lenError`. The FSM stays in DATA until `WLAST`.
  - `beatCnt` wraps modulo 16.
- RESP:
  - `WriteResponseSel` = `grant`.
  - On `BVALID && BREADY`: pulse `finish`, set `lastGrant` = `grant`, go to IDLE.
- Only one transaction is in flight. Requests arriving in non-IDLE states are ignored until the next IDLE.
- A master dropping `AWVALID` in ADDR is an AXI violation; it is not checked.

## Timing
- Reset values: state = IDLE, `lastGrant` = M1, `beatCnt` = 0, `lenReg` = 0. All outputs are 0.
- A synchronous reset mid-transaction returns the FSM to IDLE on the next edge; the selects drop to 2'b00 in that same cycle.
- Request-to-`AWVALID` latency is 1 cycle (IDLE → ADDR).
- Minimum transaction length for a single-beat burst with ready handshakes is 4 cycles. The first request is accepted again one cycle after `finish`.
- Outputs are decoded from registered state. `AWVALID`/`AWADDR` are passthroughs; `finish` and `lenError` are combinational pulses qualified by state.
- If both requests are present in IDLE in the same cycle, the arbitration rule below decides.

## Configuration
- `WRITE_ARB_ROUND_ROBIN_EN` defined: round-robin; the master that is not `lastGrant` wins a tie. Because of the reset value of `lastGrant`, the first tie after reset goes to M0.
- Undefined: fixed priority, M0 always wins a tie; `lastGrant` is still updated but unused.

## Test plan
- Single M1 write, `AWLEN_M1` = 0, ready inputs high:
  - Cycle 1: `WriteAddressSel` = 2'b10, `MasterID` = 4'd2.
  - Cycle 2: DATA. Cycle 3: RESP. `finish` pulses on the B handshake.
  - `lenError` stays 0.
- Both masters request continuously, `AWLEN` = 3:
  - With `WRITE_ARB_ROUND_ROBIN_EN`, grants alternate M0, M1, M0.
  - Without it, grants go M0, M0, M0.
- M0 burst with `AWLEN_M0` = 3 but `WLAST` on beat 2 → `lenError` pulses for 1 cycle and the FSM enters RESP.
- `AWREADY` held low for 5 cycles in ADDR → `AWVALID` = 1 and `AWADDR` = `AWADDR_M0` held stable; no state advance.
- Reset asserted during DATA → next cycle all selects = 2'b00, state IDLE; a new `AWVALID_M1` is granted one cycle later.
- `BVALID` high with `BREADY` low for 3 cycles → `WriteResponseSel` held; `finish` only on the handshake cycle.
